// File: rtl/dino_pkg.sv
// Shared constants for the dino game input path.
// Provides the default debounce length, the index of each bit of the
// game_tick bus, and the channel index of each push-button.
package dino_pkg;

    // About 1 ms at 50 MHz: longer than contact bounce, shorter than a human tap.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

    // game_tick bit indices
    localparam int TICK_FRAME = 0;
    localparam int TICK_PHYS  = 1;

    // Button channel indices
    localparam int BTN_UP   = 0;
    localparam int BTN_DOWN = 1;

    // Width of a counter that must hold values 0 .. cycles.
    function automatic int debounce_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button channel: 2-FF synchroniser followed by a stability-counter
// debouncer.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   raw    asynchronous raw button level
//   level  debounced button level (registered)
//   rise   strobe, high during the cycle whose closing edge flips level 0->1
module button_debounce
    import dino_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
)
(
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int              CNT_W    = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             deb_r;
    logic [CNT_W-1:0] cnt_r;
    logic             differ_s;
    logic             mature_s;

    // Decode whether the synchronised input disagrees and whether this edge matures it.
    always_comb begin
        differ_s = sync2_r ^ deb_r;
        mature_s = differ_s & (cnt_r == CNT_LAST);
    end

    // Synchroniser, debounced state and stability counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            deb_r   <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            if (!differ_s) begin
                // Input agrees again: any partial progress is a glitch, discard it.
                cnt_r <= CNT_ZERO;
            end else if (mature_s) begin
                deb_r <= sync2_r;
                cnt_r <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    // Drive outputs; rise is combinational so the parent can act on the same edge.
    always_comb begin
        level = deb_r;
        rise  = mature_s & sync2_r;
    end

endmodule

// File: rtl/button_conditioner.sv
// Input stage for player_controller: conditions the two raw push-buttons.
// Each button is synchronised and debounced; the up button additionally has a
// press latch so a tap shorter than a frame is held until the next frame tick.
// Ports:
//   clk             system clock
//   reset           synchronous, active-high reset
//   btn_up_raw      raw up/jump button (asynchronous)
//   btn_down_raw    raw down/duck button (asynchronous)
//   game_tick[1:0]  [0] frame tick (consumer sampling point), [1] physics tick (unused)
//   button_up       debounced up level OR latched pending press
//   button_down     debounced down level
//   up_press_pulse  one-cycle pulse after the debounced up rising edge
module button_conditioner
    import dino_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up_raw,
    input  logic       btn_down_raw,
    input  logic [1:0] game_tick,
    output logic       button_up,
    output logic       button_down,
    output logic       up_press_pulse
);

    logic deb_up_s;
    logic deb_down_s;
    logic up_rise_s;
    logic down_rise_s;
    logic up_pending_r;
    logic up_press_pulse_r;
    logic unused_ok_s;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_up (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_up_raw),
        .level (deb_up_s),
        .rise  (up_rise_s)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_down (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_down_raw),
        .level (deb_down_s),
        .rise  (down_rise_s)
    );

    // Press pulse and pending-press latch for the up button.
    always_ff @(posedge clk) begin
        if (reset) begin
            up_press_pulse_r <= 1'b0;
            up_pending_r     <= 1'b0;
        end else begin
            up_press_pulse_r <= up_rise_s;
            // Set wins: a frame tick coinciding with maturity has not seen the press yet.
            if (up_rise_s) begin
                up_pending_r <= 1'b1;
            end else if (game_tick[TICK_FRAME]) begin
                up_pending_r <= 1'b0;
            end else begin
                up_pending_r <= up_pending_r;
            end
        end
    end

    // Output drive; button_up is an OR of two registers so it cannot glitch.
    always_comb begin
        button_up      = deb_up_s | up_pending_r;
        button_down    = deb_down_s;
        up_press_pulse = up_press_pulse_r;
        // Physics tick and the down rise strobe have no consumer in this block.
        unused_ok_s    = game_tick[TICK_PHYS] ^ down_rise_s;
    end

endmodule
